gnn_layer_engine: RTL and testbench
===================================

Name: gnn_layer_engine

Overview:
- Parametrised, time-multiplexed graph-convolution layer for the GNN accelerator datapath.
- Accepts one feature vector per node over a valid/ready stream.
- Aggregates each node's neighbourhood under a run-time adjacency mask, then applies a shared F_IN x F_OUT weight matrix with one MAC bank.
- Emits one output vector per node. Replaces hard-wired 4-node aggregation and fully parallel multipliers; layers chain back-to-back.

Parameters:
N_NODES, 4, number of graph nodes (>=2)
F_IN, 4, input features per node
F_OUT, 2, output features per node
DW, 5, signed input feature width
WW, 5, signed weight width
ACC_W, 21, signed output/accumulator width

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-high reset
adj  in  N_NODES*N_NODES  bit i*N_NODES+j = node i aggregates node j (self included only if bit set)
weights  in  F_IN*F_OUT*WW  signed weight k,o at slice (k*F_OUT+o)*WW
relu_en  in  1  1 = clamp negative outputs to 0
in_valid  in  1  input beat valid
in_ready  out  1  engine can accept input beat
in_data  in  F_IN*DW  one node's features, feature k at slice k*DW
out_valid  out  1  output beat valid
out_ready  in  1  downstream accepts output
out_node  out  clog2(N_NODES)  node index of current output
out_data  out  F_OUT*ACC_W  output feature o at slice o*ACC_W
busy  out  1  high in any state except IDLE

Behaviour:
- Reset: state=IDLE; in_ready=1; out_valid=0; out_node=0; out_data=0; busy=0; feature RAM, indices and accumulators cleared. Reset mid-run aborts; partial results are discarded.
- Handshake: beat transfers when valid&&ready at a rising edge. in_ready=1 only in IDLE/LOAD. out_valid stays high and out_data/out_node stay stable until out_ready.
- Config capture: adj, weights and relu_en are registered on the first accepted input beat of a run. Later changes do not affect the run in flight.
- FSM:
  - IDLE: first beat stores node 0 -> LOAD.
  - LOAD: stores beats into nodes 1..N_NODES-1. Last beat -> AGG with i=0.
  - AGG: N_NODES cycles, j=0..N_NODES-1. If adj[i][j], add node j's F_IN features into F_IN parallel aggregate registers of width DW+clog2(N_NODES); no overflow is possible. Then -> MAC.
  - MAC: F_IN cycles, k=0..F_IN-1. For each o, acc[o] += agg[k]*w[k][o], computed in full precision and then saturated to ACC_W. Then -> OUT.
  - OUT: out_valid=1, out_node=i. out_data = acc, ReLU applied if relu_en (applied after saturation). On out_ready: clear acc and agg. If i=N_NODES-1 -> IDLE, else i++ -> AGG.
- Latency: the first out_valid rises N_NODES+F_IN+1 cycles after the edge that accepts the last input beat (9 with defaults). Each further node takes N_NODES+F_IN+1 cycles after the previous out handshake.
- Boundaries:
  - An adjacency row of all zeros gives out_data=0 for that node.
  - Saturation is sticky within a node: once saturated, the accumulator holds its rail value until cleared.
  - out_ready held low stalls in OUT indefinitely without data loss.
  - in_valid is ignored while busy outside LOAD.
  - The final out handshake returns to IDLE with in_ready=1 in the next cycle; a new run may start then.

Test Plan:
- Defaults. adj rows {0,1,2},{0,1,3},{0,2,3},{1,2,3}. All features=1, all weights=1, relu_en=0, out_ready=1 -> four beats, out_node 0..3 in order, every out_data element = 12, first out_valid 9 cycles after the last input beat.
- Same adj. Node features all -2, weights all +1, relu_en=1 -> outputs = 0. Repeat with relu_en=0 -> outputs = -24.
- ACC_W=12, adj all ones, features all -16, weights all -16 -> each MAC step adds 1024, so the accumulator saturates to 2047. Repeat with weights all +15 -> saturates to -2048.
- Node 2 adj row = 0, other rows all ones, features=3, weights=1 -> node 2 outputs 0, other nodes output 48.
- out_ready held low for 20 cycles on node 1 -> out_valid, out_node=1 and out_data hold stable throughout. In this state in_ready=0, and changing adj/weights has no effect on any result.
- Assert rst during MAC of node 2 -> immediately out_valid=0, busy=0, in_ready=1. The next full run gives the same results as the first scenario.

Source files
------------

// File: rtl/gnn_layer_engine.sv
// gnn_layer_engine: time-multiplexed graph-convolution layer.
// Buffers one feature vector per node, aggregates each node's masked neighbourhood, then applies shared weights through one MAC bank.
module gnn_layer_engine #(
  parameter int N_NODES = 4,
  parameter int F_IN    = 4,
  parameter int F_OUT   = 2,
  parameter int DW      = 5,
  parameter int WW      = 5,
  parameter int ACC_W   = 21
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [N_NODES*N_NODES-1:0]   adj,
  input  logic [F_IN*F_OUT*WW-1:0]     weights,
  input  logic                         relu_en,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [F_IN*DW-1:0]           in_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [$clog2(N_NODES)-1:0]   out_node,
  output logic [F_OUT*ACC_W-1:0]       out_data,
  output logic                         busy
);
  localparam int NW  = $clog2(N_NODES);
  localparam int KW  = (F_IN > 1) ? $clog2(F_IN) : 1;
  localparam int AGW = DW + NW;
  localparam int PW  = AGW + WW;
  localparam int SW  = ((ACC_W > PW) ? ACC_W : PW) + 1;
  localparam logic [NW-1:0] LAST_NODE = NW'(N_NODES - 1);
  localparam logic [KW-1:0] LAST_K    = KW'(F_IN - 1);
  localparam logic signed [ACC_W-1:0] AMAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] AMIN = {1'b1, {(ACC_W-1){1'b0}}};

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_AGG, S_MAC, S_OUT} state_t;
  state_t state, state_nxt;

  logic [N_NODES*N_NODES-1:0] adj_r;
  logic [F_IN*F_OUT*WW-1:0]   w_r;
  logic                       relu_r;
  logic signed [DW-1:0]       feat    [N_NODES][F_IN];
  logic signed [DW-1:0]       in_feat [F_IN];
  logic signed [WW-1:0]       w_m     [F_IN][F_OUT];
  logic                       adj_m   [N_NODES][N_NODES];
  logic [NW-1:0]              ld_idx, node_idx, agg_idx;
  logic [KW-1:0]              mac_idx;
  logic signed [AGW-1:0]      agg [F_IN];
  logic signed [ACC_W-1:0]    acc [F_OUT];
  logic                       sat [F_OUT];
  logic signed [SW-1:0]       sum [F_OUT];
  logic [F_OUT*ACC_W-1:0]     res;
  logic                       in_fire, out_fire;

  assign in_ready = (state == S_IDLE) || (state == S_LOAD);
  assign busy     = (state != S_IDLE);
  assign in_fire  = in_valid && in_ready;
  assign out_fire = out_valid && out_ready;
  assign out_node = node_idx;

  always_comb begin
    for (int unsigned k = 0; k < F_IN; k++) begin
      in_feat[k] = in_data[k*DW +: DW];
      for (int unsigned o = 0; o < F_OUT; o++)
        w_m[k][o] = w_r[(k*F_OUT+o)*WW +: WW];
    end
    for (int unsigned i = 0; i < N_NODES; i++)
      for (int unsigned j = 0; j < N_NODES; j++)
        adj_m[i][j] = adj_r[i*N_NODES+j];
  end

  // Full-precision MAC step; saturation happens when the result is written back.
  always_comb begin
    res = '0;
    for (int unsigned o = 0; o < F_OUT; o++) begin
      sum[o] = SW'(acc[o]) + SW'(agg[mac_idx]) * SW'(w_m[mac_idx][o]);
      res[o*ACC_W +: ACC_W] = (relu_r && acc[o][ACC_W-1]) ? '0 : acc[o];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (in_fire) state_nxt = S_LOAD;
      S_LOAD: if (in_fire && ld_idx == LAST_NODE) state_nxt = S_AGG;
      S_AGG:  if (agg_idx == LAST_NODE) state_nxt = S_MAC;
      S_MAC:  if (mac_idx == LAST_K) state_nxt = S_OUT;
      S_OUT:  if (out_fire) state_nxt = (node_idx == LAST_NODE) ? S_IDLE : S_AGG;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      adj_r     <= '0;
      w_r       <= '0;
      relu_r    <= 1'b0;
      ld_idx    <= '0;
      node_idx  <= '0;
      agg_idx   <= '0;
      mac_idx   <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      for (int unsigned n = 0; n < N_NODES; n++)
        for (int unsigned k = 0; k < F_IN; k++)
          feat[n][k] <= '0;
      for (int unsigned k = 0; k < F_IN; k++) agg[k] <= '0;
      for (int unsigned o = 0; o < F_OUT; o++) begin
        acc[o] <= '0;
        sat[o] <= 1'b0;
      end
    end else begin
      case (state)
        S_IDLE, S_LOAD: if (in_fire) begin
          if (state == S_IDLE) begin
            adj_r    <= adj;
            w_r      <= weights;
            relu_r   <= relu_en;
            node_idx <= '0;
          end
          for (int unsigned k = 0; k < F_IN; k++) feat[ld_idx][k] <= in_feat[k];
          ld_idx <= (ld_idx == LAST_NODE) ? '0 : ld_idx + 1'b1;
        end
        S_AGG: begin
          if (adj_m[node_idx][agg_idx])
            for (int unsigned k = 0; k < F_IN; k++)
              agg[k] <= agg[k] + AGW'(feat[agg_idx][k]);
          agg_idx <= (agg_idx == LAST_NODE) ? '0 : agg_idx + 1'b1;
        end
        S_MAC: begin
          for (int unsigned o = 0; o < F_OUT; o++) begin
            if (!sat[o]) begin
              if (sum[o] > SW'(AMAX)) begin
                acc[o] <= AMAX;
                sat[o] <= 1'b1;
              end else if (sum[o] < SW'(AMIN)) begin
                acc[o] <= AMIN;
                sat[o] <= 1'b1;
              end else begin
                acc[o] <= ACC_W'(sum[o]);
              end
            end
          end
          mac_idx <= (mac_idx == LAST_K) ? '0 : mac_idx + 1'b1;
        end
        S_OUT: begin
          // Output is registered: out_valid rises one cycle after entering OUT.
          if (!out_valid) begin
            out_valid <= 1'b1;
            out_data  <= res;
          end else if (out_ready) begin
            out_valid <= 1'b0;
            for (int unsigned k = 0; k < F_IN; k++) agg[k] <= '0;
            for (int unsigned o = 0; o < F_OUT; o++) begin
              acc[o] <= '0;
              sat[o] <= 1'b0;
            end
            node_idx <= (node_idx == LAST_NODE) ? '0 : node_idx + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_gnn_layer_engine.sv
// Directed bench for gnn_layer_engine: default build plus an ACC_W=12 build driven in lockstep.
module tb_gnn_layer_engine;
  localparam int N = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] adj = '0;
  logic [39:0] weights = '0;
  logic        relu_en = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b1;
  logic [19:0] in_data = '0;
  logic        in_ready, out_valid, busy;
  logic        in_ready12, out_valid12, busy12;
  logic [1:0]  out_node, out_node12;
  logic [41:0] out_data;
  logic [23:0] out_data12;
  int          n_vec = 0;
  int          n_err = 0;

  gnn_layer_engine dut (
    .clk(clk), .rst(rst), .adj(adj), .weights(weights), .relu_en(relu_en),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_node(out_node),
    .out_data(out_data), .busy(busy)
  );

  gnn_layer_engine #(.ACC_W(12)) dut12 (
    .clk(clk), .rst(rst), .adj(adj), .weights(weights), .relu_en(relu_en),
    .in_valid(in_valid), .in_ready(in_ready12), .in_data(in_data),
    .out_valid(out_valid12), .out_ready(out_ready), .out_node(out_node12),
    .out_data(out_data12), .busy(busy12)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] adj;
    int          w;
    logic [19:0] fd;
    logic        relu;
    int          stall;
    int          abrt;
    int          e21 [4];
    int          e12 [4];
  } vec_t;

  vec_t tv [10];

  task automatic chk(input string name, input logic signed [63:0] act, input logic signed [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual %0d, required %0d", name, act, exp);
    end
  endtask

  function automatic logic signed [63:0] d21(input int o);
    return $signed(out_data[o*21 +: 21]);
  endfunction

  function automatic logic signed [63:0] d12(input int o);
    return $signed(out_data12[o*12 +: 12]);
  endfunction

  task automatic run(input int v);
    int lat;
    logic [41:0] hold;
    @(negedge clk);
    adj      = tv[v].adj;
    weights  = {8{5'(tv[v].w)}};
    relu_en  = tv[v].relu;
    in_data  = tv[v].fd;
    in_valid = 1'b1;
    chk($sformatf("v%0d in_ready idle", v), in_ready, 1);
    repeat (N) @(posedge clk);
    #1 in_valid = 1'b0;
    in_data = '0;
    for (int n = 0; n < N; n++) begin
      if (n == tv[v].abrt) begin
        repeat (6) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        chk($sformatf("v%0d abort idle flags", v),
            {out_valid, busy, in_ready, out_valid12, busy12, in_ready12}, 6'b001001);
        chk($sformatf("v%0d abort out_data", v), out_data, 0);
        chk($sformatf("v%0d abort out_node", v), out_node, 0);
        @(negedge clk);
        rst = 1'b0;
        return;
      end
      lat = 0;
      while (out_valid !== 1'b1 && lat < 100) begin
        @(posedge clk);
        #1 lat++;
      end
      chk($sformatf("v%0d n%0d latency", v, n), lat, 9);
      chk($sformatf("v%0d n%0d out_node", v, n), out_node, n);
      chk($sformatf("v%0d n%0d acc12 valid/node", v, n), {out_valid12, out_node12}, {1'b1, 2'(n)});
      for (int o = 0; o < 2; o++) begin
        chk($sformatf("v%0d n%0d o%0d data", v, n, o), d21(o), tv[v].e21[n]);
        chk($sformatf("v%0d n%0d o%0d data12", v, n, o), d12(o), tv[v].e12[n]);
      end
      if (n == tv[v].stall) begin
        out_ready = 1'b0;
        hold = out_data;
        for (int c = 0; c < 20; c++) begin
          in_valid = 1'b1;
          adj      = 16'($urandom);
          weights  = {8'($urandom), $urandom};
          relu_en  = ~relu_en;
          @(posedge clk);
          #1;
          chk($sformatf("v%0d stall c%0d hold", v, c),
              {out_valid, out_node, out_data == hold, in_ready}, {1'b1, 2'(n), 1'b1, 1'b0});
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
      end
      @(posedge clk);
      #1;
    end
    chk($sformatf("v%0d idle after run", v), {in_ready, busy}, 2'b10);
  endtask

  initial begin
    // adj rows (bit j of row i): {0,1,2},{0,1,3},{0,2,3},{1,2,3}
    tv[0] = '{16'hEDB7,   1, {4{5'd1}},  1'b0, -1, -1, '{12, 12, 12, 12}, '{12, 12, 12, 12}};
    tv[1] = '{16'hEDB7,   1, {4{5'h1E}}, 1'b1, -1, -1, '{0, 0, 0, 0}, '{0, 0, 0, 0}};
    tv[2] = '{16'hEDB7,   1, {4{5'h1E}}, 1'b0, -1, -1, '{-24, -24, -24, -24}, '{-24, -24, -24, -24}};
    tv[3] = '{16'hFFFF, -16, {4{5'h10}}, 1'b0, -1, -1, '{4096, 4096, 4096, 4096}, '{2047, 2047, 2047, 2047}};
    tv[4] = '{16'hFFFF,  15, {4{5'h10}}, 1'b0, -1, -1, '{-3840, -3840, -3840, -3840}, '{-2048, -2048, -2048, -2048}};
    tv[5] = '{16'hF0FF,   1, {4{5'd3}},  1'b0, -1, -1, '{48, 48, 0, 48}, '{48, 48, 0, 48}};
    // features -16,-16,-16,+15: a late negative product must not pull a saturated acc back
    tv[6] = '{16'hFFFF, -16, {5'd15, 5'h10, 5'h10, 5'h10}, 1'b0, -1, -1, '{2112, 2112, 2112, 2112}, '{2047, 2047, 2047, 2047}};
    tv[7] = '{16'hEDB7,   1, {4{5'd1}},  1'b0,  1, -1, '{12, 12, 12, 12}, '{12, 12, 12, 12}};
    tv[8] = '{16'hEDB7,   1, {4{5'd1}},  1'b0, -1,  2, '{12, 12, 12, 12}, '{12, 12, 12, 12}};
    tv[9] = '{16'hEDB7,   1, {4{5'd1}},  1'b0, -1, -1, '{12, 12, 12, 12}, '{12, 12, 12, 12}};

    #12;
    chk("reset flags", {in_ready, out_valid, busy}, 3'b100);
    chk("reset out_node", out_node, 0);
    chk("reset out_data", out_data, 0);
    @(negedge clk);
    rst = 1'b0;
    for (int v = 0; v < 10; v++) run(v);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: actual timeout, required completion");
    $fatal(1);
  end
endmodule
